// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parity_pkg
//  Description : Shared types and constants for the parity frame transmitter.
//                Holds the frame FSM state encoding and the parity-sense
//                selector constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package parity_pkg;

    // Frame FSM: idle, serialising data bits, presenting the parity bit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    // XORed into the accumulated parity to select its sense.
    localparam logic PARITY_EVEN    = 1'b0;
    localparam logic PARITY_ODD_SEL = 1'b1;

endpackage : parity_pkg
`default_nettype wire

// File: rtl/parity_accum.sv
`default_nettype none
// ============================================================================
//  Module      : parity_accum
//  Description : Running parity accumulator. Toggles on every enabled '1'
//                bit; cleared by clr or rst (rst takes priority).
//  Ports       : clk    - clock, rising edge
//                rst    - synchronous active-high reset
//                clr    - synchronous clear (start of a new frame)
//                en     - accumulate bit_in this cycle
//                bit_in - bit being accumulated
//                parity - XOR of all accumulated bits since last clear
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_accum (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic parity
);

    logic r_parity;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_parity <= 1'b0;
        end else if (en && bit_in) begin
            r_parity <= ~r_parity;
        end
    end

    assign parity = r_parity;

endmodule : parity_accum
`default_nettype wire

// File: rtl/parity_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : parity_frame_tx
//  Description : Frames a parallel DATA_W-bit word into a serial stream,
//                data LSB first followed by one parity bit, with
//                valid/ready handshakes on both sides. Back-to-back frames
//                are supported: a new word can be accepted in the same cycle
//                the parity bit is consumed.
//  Parameters  : DATA_W     - data bits per frame (2..32)
//                PARITY_ODD - 0: even parity bit, 1: odd parity bit
//  Ports       : clk       - clock, rising edge
//                rst       - synchronous active-high reset
//                in_data   - parallel word to frame
//                in_valid  - in_data valid
//                in_ready  - word accepted when in_valid && in_ready
//                ser_out   - serial bit (data LSB first, then parity)
//                ser_valid - ser_out carries a frame bit
//                ser_ready - downstream consumes ser_out this cycle
//                ser_last  - ser_out is the parity bit
//                busy      - a frame is in progress
//                frame_cnt - (PARITY_FRAME_CNT_EN only) 16-bit count of
//                            completed frames, wraps 0xFFFF -> 0x0000
//  Build macro : PARITY_FRAME_CNT_EN adds the frame_cnt output.
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_tx
    import parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_last,
    output logic              busy
`ifdef PARITY_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    localparam int                CNT_W        = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  C_LAST_BIT   = CNT_W'(DATA_W - 1);
    localparam logic              C_PARITY_SEL = (PARITY_ODD != 0) ? PARITY_ODD_SEL : PARITY_EVEN;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_parity;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_load;
    logic               w_shift;

    // ------------------------------------------------------------------
    // Output decode from the current state
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        ser_last  = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
            end
            DATA: begin
                ser_valid = 1'b1;
                ser_out   = r_shift[0];
                busy      = 1'b1;
            end
            PAR: begin
                // A new word may only enter when the parity bit leaves,
                // so acceptance follows the downstream ready.
                in_ready  = ser_ready;
                ser_valid = 1'b1;
                ser_last  = 1'b1;
                ser_out   = w_parity ^ C_PARITY_SEL;
                busy      = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = ser_valid && ser_ready;
    assign w_load     = w_in_xfer;
    assign w_shift    = (r_state == DATA) && w_out_xfer;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_in_xfer) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_out_xfer && (r_cnt == C_LAST_BIT)) begin
                    w_state_nxt = PAR;
                end
            end
            PAR: begin
                if (w_out_xfer) begin
                    w_state_nxt = w_in_xfer ? DATA : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Shift register and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_shift <= in_data;
            r_cnt   <= '0;
        end else if (w_shift) begin
            r_shift <= r_shift >> 1;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Running parity of the bits actually sent in this frame.
    parity_accum u_parity_accum (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_load),
        .en     (w_shift),
        .bit_in (r_shift[0]),
        .parity (w_parity)
    );

`ifdef PARITY_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Counts frames whose parity bit was consumed; natural 16-bit wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= 16'd0;
        end else if ((r_state == PAR) && w_out_xfer) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule : parity_frame_tx
`default_nettype wire

// File: tb/tb_parity_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parity_frame_tx
//  Description : Self-checking bench for parity_frame_tx. Two instances
//                (even and odd parity) share one stimulus; a queue-based
//                frame model predicts every output each cycle, and literal
//                bit streams pin the model on the directed frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_frame_tx;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       ser_ready;

    logic e_in_ready, e_ser_out, e_ser_valid, e_ser_last, e_busy;
    logic o_in_ready, o_ser_out, o_ser_valid, o_ser_last, o_busy;
`ifdef PARITY_FRAME_CNT_EN
    logic [15:0] e_frame_cnt;
    logic [15:0] o_frame_cnt;
`endif

    parity_frame_tx #(.DATA_W(8), .PARITY_ODD(0)) dut_even (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (e_in_ready),
        .ser_out   (e_ser_out),
        .ser_valid (e_ser_valid),
        .ser_ready (ser_ready),
        .ser_last  (e_ser_last),
        .busy      (e_busy)
`ifdef PARITY_FRAME_CNT_EN
        ,
        .frame_cnt (e_frame_cnt)
`endif
    );

    parity_frame_tx #(.DATA_W(8), .PARITY_ODD(1)) dut_odd (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (o_in_ready),
        .ser_out   (o_ser_out),
        .ser_valid (o_ser_valid),
        .ser_ready (ser_ready),
        .ser_last  (o_ser_last),
        .busy      (o_busy)
`ifdef PARITY_FRAME_CNT_EN
        ,
        .frame_cnt (o_frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: bits still owed to the serial side for the current frame.
    bit        q_e[$];
    bit        q_o[$];
    bit [15:0] m_cnt;
    bit        known;

    // Capture of consumed serial bits for literal stream checks.
    int          ncap;
    logic [31:0] cap_e;
    logic [31:0] cap_o;
    int          nval;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        if (q_e.size() == 0) return 1'b1;
        if (q_e.size() == 1) return ser_ready;
        return 1'b0;
    endfunction

    task automatic compare();
        bit v, l, r, oe, oo;
        v  = (q_e.size() != 0);
        l  = (q_e.size() == 1);
        r  = m_ready();
        oe = v ? q_e[0] : 1'b0;
        oo = v ? q_o[0] : 1'b0;
        chk("even in_ready",  32'(e_in_ready),  32'(r));
        chk("even ser_valid", 32'(e_ser_valid), 32'(v));
        chk("even ser_last",  32'(e_ser_last),  32'(l));
        chk("even ser_out",   32'(e_ser_out),   32'(oe));
        chk("even busy",      32'(e_busy),      32'(v));
        chk("odd in_ready",   32'(o_in_ready),  32'(r));
        chk("odd ser_valid",  32'(o_ser_valid), 32'(v));
        chk("odd ser_last",   32'(o_ser_last),  32'(l));
        chk("odd ser_out",    32'(o_ser_out),   32'(oo));
        chk("odd busy",       32'(o_busy),      32'(v));
`ifdef PARITY_FRAME_CNT_EN
        chk("even frame_cnt", 32'(e_frame_cnt), 32'(m_cnt));
        chk("odd frame_cnt",  32'(o_frame_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic model_update();
        bit out_x, in_x, p;
        if (rst) begin
            q_e.delete();
            q_o.delete();
            m_cnt = 16'd0;
            known = 1'b1;
        end else begin
            out_x = (q_e.size() != 0) && ser_ready;
            in_x  = in_valid && m_ready();
            if (out_x) begin
                if (q_e.size() == 1) m_cnt = m_cnt + 16'd1;
                void'(q_e.pop_front());
                void'(q_o.pop_front());
            end
            if (in_x) begin
                p = ^in_data;
                for (int i = 0; i < 8; i++) begin
                    q_e.push_back(in_data[i]);
                    q_o.push_back(in_data[i]);
                end
                q_e.push_back(p);
                q_o.push_back(~p);
            end
        end
    endtask

    // One clock cycle: apply inputs, check outputs, advance the model.
    task automatic cyc(input logic v, input logic [7:0] d, input logic sr, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        ser_ready = sr;
        rst       = r;
        #1;
        if (known) begin
            compare();
            if (e_ser_valid) nval++;
            if (e_ser_valid && ser_ready && !rst && ncap < 32) begin
                cap_e[ncap] = e_ser_out;
                cap_o[ncap] = o_ser_out;
                ncap++;
            end
        end
        @(posedge clk);
        model_update();
    endtask

    task automatic cap_start();
        ncap  = 0;
        nval  = 0;
        cap_e = '0;
        cap_o = '0;
    endtask

    // Sends one word with ser_ready held high and idles for the frame.
    task automatic send_word(input logic [7:0] d);
        cap_start();
        cyc(1'b1, d, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        ser_ready = 1'b0;
        known     = 1'b0;
        m_cnt     = 16'd0;
        cap_start();

        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset state, pinned with literals.
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; ser_ready = 1'b0;
        #1;
        chk("reset in_ready",  32'(e_in_ready),  32'd1);
        chk("reset ser_valid", 32'(e_ser_valid), 32'd0);
        chk("reset ser_out",   32'(e_ser_out),   32'd0);
        chk("reset ser_last",  32'(e_ser_last),  32'd0);
        chk("reset busy",      32'(e_busy),      32'd0);
`ifdef PARITY_FRAME_CNT_EN
        chk("reset frame_cnt", 32'(e_frame_cnt), 32'd0);
`endif
        @(posedge clk);
        model_update();

        // 0xA5: bits 1,0,1,0,0,1,0,1 then even parity 0 / odd parity 1.
        send_word(8'hA5);
        chk("A5 even stream", 32'(cap_e[8:0]), 32'h0A5);
        chk("A5 odd stream",  32'(cap_o[8:0]), 32'h1A5);
        chk("A5 bit count",   ncap,            32'd9);

        // 0x07: three ones, even parity bit 1.
        send_word(8'h07);
        chk("07 even stream", 32'(cap_e[8:0]), 32'h107);
        chk("07 odd stream",  32'(cap_o[8:0]), 32'h007);

        // Back-to-back 0xFF then 0x00 with in_valid held.
        cap_start();
        cyc(1'b1, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b1, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("FF/00 even stream", 32'(cap_e[17:0]), 32'h000FF);
        chk("FF/00 valid cycles", nval,            32'd18);

        // 0x3C with stalls during bit 4 and during the parity bit.
        cap_start();
        cyc(1'b1, 8'h3C, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h55, 1'b0, 1'b0);
        chk("3C stalled PAR in_ready", 32'(e_in_ready), 32'd0);
        chk("3C stalled PAR last",     32'(e_ser_last), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("3C even stream", 32'(cap_e[8:0]), 32'h03C);
        chk("3C odd stream",  32'(cap_o[8:0]), 32'h13C);

        // Reset during bit 5 of 0x81, then 0x01.
        cyc(1'b1, 8'h81, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; ser_ready = 1'b1;
        #1;
        chk("post-rst ser_valid", 32'(e_ser_valid), 32'd0);
        chk("post-rst in_ready",  32'(e_in_ready),  32'd1);
        chk("post-rst ser_last",  32'(e_ser_last),  32'd0);
        @(posedge clk);
        model_update();
        send_word(8'h01);
        chk("01 even stream", 32'(cap_e[8:0]), 32'h101);
        chk("01 odd stream",  32'(cap_o[8:0]), 32'h001);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            cyc(1'($urandom_range(0, 1)),
                8'($urandom),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 199) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_parity_frame_tx
`default_nettype wire
